// File: rtl/writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_arbiter                                            |
// | Description : Round-robin arbiter that shares one register-file writeback  |
// |               port between NumEus execution units. The winning result is   |
// |               registered in a one-entry output stage. Each completed       |
// |               writeback produces a one-cycle tag-release pulse for the     |
// |               dispatcher.                                                  |
// | Ports       : clk_i, rst_i (async, active-high)                            |
// |               eu_valid_i / eu_ready_o          per-EU handshake            |
// |               eu_tag_i / eu_dst_i / eu_act_mask_i / eu_data_i              |
// |                                                 per-EU payload (flattened) |
// |               wb_valid_o / wb_ready_i          writeback handshake         |
// |               wb_tag_o / wb_dst_o / wb_act_mask_o / wb_data_o              |
// |                                                 held result payload        |
// |               disp_eu_valid_o / disp_eu_tag_o  tag-release to dispatcher   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module writeback_arbiter #(
    parameter  int NumEus      = 4,
    parameter  int NumTags     = 8,
    parameter  int RegIdxWidth = 6,
    parameter  int WarpWidth   = 32,
    parameter  int DataWidth   = 32,
    localparam int TagWidth    = (NumTags > 1) ? $clog2(NumTags) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumEus-1:0]                     eu_valid_i,
    output logic [NumEus-1:0]                     eu_ready_o,
    input  logic [NumEus*TagWidth-1:0]            eu_tag_i,
    input  logic [NumEus*RegIdxWidth-1:0]         eu_dst_i,
    input  logic [NumEus*WarpWidth-1:0]           eu_act_mask_i,
    input  logic [NumEus*WarpWidth*DataWidth-1:0] eu_data_i,
    output logic                                  wb_valid_o,
    input  logic                                  wb_ready_i,
    output logic [TagWidth-1:0]                   wb_tag_o,
    output logic [RegIdxWidth-1:0]                wb_dst_o,
    output logic [WarpWidth-1:0]                  wb_act_mask_o,
    output logic [WarpWidth*DataWidth-1:0]        wb_data_o,
    output logic                                  disp_eu_valid_o,
    output logic [TagWidth-1:0]                   disp_eu_tag_o
);

    localparam int PtrWidth = (NumEus > 1) ? $clog2(NumEus) : 1;
    localparam int LaneBits = WarpWidth * DataWidth;
    localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(NumEus - 1);

    // Round-robin pointer: index of the highest-priority requester.
    logic [PtrWidth-1:0]    ptr_q, ptr_d;

    // One-entry output stage.
    logic                   wb_valid_q;
    logic [TagWidth-1:0]    wb_tag_q;
    logic [RegIdxWidth-1:0] wb_dst_q;
    logic [WarpWidth-1:0]   wb_mask_q;
    logic [LaneBits-1:0]    wb_data_q;

    logic                   can_accept;
    logic                   grant_any;
    logic [PtrWidth-1:0]    grant_idx;
    logic [NumEus-1:0]      grant_oh;
    logic [TagWidth-1:0]    sel_tag;
    logic [RegIdxWidth-1:0] sel_dst;
    logic [WarpWidth-1:0]   sel_mask;
    logic [LaneBits-1:0]    sel_data;

    // Stage takes a new result when empty or when the held one drains now.
    // Grants are suppressed while reset is held so no EU sees a handshake
    // that the (cleared) stage would not honour.
    assign can_accept = (!wb_valid_q || wb_ready_i) && !rst_i;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (can_accept) begin
            for (int k = 0; k < NumEus; k++) begin
                idx = (int'(ptr_q) + k) % NumEus;
                if (!grant_any && eu_valid_i[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = PtrWidth'(idx);
                end
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign eu_ready_o = grant_oh;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
        end
    end

    // Payload of the winning EU.
    assign sel_tag  = eu_tag_i[int'(grant_idx)*TagWidth +: TagWidth];
    assign sel_dst  = eu_dst_i[int'(grant_idx)*RegIdxWidth +: RegIdxWidth];
    assign sel_mask = eu_act_mask_i[int'(grant_idx)*WarpWidth +: WarpWidth];
    assign sel_data = eu_data_i[int'(grant_idx)*LaneBits +: LaneBits];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_dst_q   <= '0;
            wb_mask_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant_any) begin
                wb_valid_q <= 1'b1;
                wb_tag_q   <= sel_tag;
                wb_dst_q   <= sel_dst;
                wb_mask_q  <= sel_mask;
                wb_data_q  <= sel_data;
            end else if (wb_ready_i) begin
                // Drained with nothing to refill; payload is don't-care.
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_tag_o      = wb_tag_q;
    assign wb_dst_o      = wb_dst_q;
    assign wb_act_mask_o = wb_mask_q;
    assign wb_data_o     = wb_data_q;

    // Tag is freed only on a completed writeback, never at grant.
    assign disp_eu_valid_o = wb_valid_q && wb_ready_i;
    assign disp_eu_tag_o   = wb_tag_q;

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(eu_ready_o));

    a_ready_implies_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (eu_ready_o & ~eu_valid_i) == '0);

    a_no_duplicate_tag : assert property (@(posedge clk_i) disable iff (rst_i)
        (grant_any && wb_valid_q) |-> (sel_tag != wb_tag_q));

    a_payload_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (wb_valid_o && !wb_ready_i) |=> (wb_valid_o && $stable(wb_tag_o) &&
        $stable(wb_dst_o) && $stable(wb_act_mask_o) && $stable(wb_data_o)));
`endif

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single result/writeback port between NumEus execution units using round-robin arbitration.
- Registers the winning result into a one-entry output stage that feeds the register file writeback.
- On every completed writeback, emits a one-cycle tag-release pulse to the dispatcher. The pulse frees the tag in the tag queue, the register table and the wait buffer.

Parameters:
- NumEus, 4, number of execution units competing for writeback.
- NumTags, 8, number of in-flight instruction tags.
- RegIdxWidth, 6, register index width.
- WarpWidth, 32, threads per warp.
- DataWidth, 32, result width per thread.
- TagWidth, $clog2(NumTags), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- eu_valid_i  in  NumEus  per-EU result valid
- eu_ready_o  out  NumEus  per-EU grant/accept
- eu_tag_i  in  NumEus x TagWidth  per-EU instruction tag
- eu_dst_i  in  NumEus x RegIdxWidth  per-EU destination register
- eu_act_mask_i  in  NumEus x WarpWidth  per-EU active thread mask
- eu_data_i  in  NumEus x WarpWidth x DataWidth  per-EU result data
- wb_valid_o  out  1  writeback valid to register file
- wb_ready_i  in  1  register file accepts writeback
- wb_tag_o  out  TagWidth  tag of the held result
- wb_dst_o  out  RegIdxWidth  destination register of the held result
- wb_act_mask_o  out  WarpWidth  active mask of the held result
- wb_data_o  out  WarpWidth x DataWidth  data of the held result
- disp_eu_valid_o  out  1  tag-release pulse to dispatcher
- disp_eu_tag_o  out  TagWidth  tag being released

Behaviour:
- Reset (rst_i high, async):
  - Output stage invalid; wb_valid_o=0; wb_* payload=0.
  - RR pointer=0; eu_ready_o=0; disp_eu_valid_o=0.
  - A result held in the output stage is dropped; no release pulse is issued for it.
- Stage accept condition: can_accept = !wb_valid_o || wb_ready_i. Pipelined: drain and refill happen in the same cycle.
- Arbitration (combinational):
  - Runs only when can_accept.
  - Scans requesters starting at the pointer, in index order with wrap, for the first eu_valid_i.
  - At most one eu_ready_o bit is high, and only for an asserted eu_valid_i.
  - When !can_accept, all eu_ready_o=0.
- On grant to i: the output stage loads EU i's tag/dst/mask/data at the next edge; pointer <= (i+1) mod NumEus.
- With no grant, the pointer holds.
- Latency: grant cycle N -> wb_valid_o=1 at N+1.
- Throughput: 1 result/cycle while wb_ready_i stays high.
- Handshake rules:
  - EU holds valid and payload stable until its eu_ready_o is seen.
  - wb_valid_o and the wb_* payload stay stable until wb_ready_i.
  - wb_valid_o never drops without a handshake, except on reset.
- Release: disp_eu_valid_o = wb_valid_o && wb_ready_i (combinational); disp_eu_tag_o = wb_tag_o. The tag is released only when the writeback completes, never at grant.
- Fairness: a continuously requesting EU waits at most NumEus-1 grants.
- Pointer wraps from NumEus-1 to 0.
- Simultaneous events:
  - Drain of the held result and grant of a new one in the same cycle is legal. The release pulse carries the old tag; the stage holds the new one next cycle.
  - Same-cycle requests from all EUs produce exactly one grant.
- Sim-only assertions:
  - eu_ready_o is onehot0.
  - eu_ready_o[i] implies eu_valid_i[i].
  - A granted tag never equals the valid held wb_tag_o (duplicate in-flight tag).
  - The wb_* payload is stable while wb_valid_o && !wb_ready_i.

Test Plan:
- Single request: EU2 valid, tag=5, dst=7, wb_ready_i=1 -> eu_ready_o=4'b0100 at cycle 0. At cycle 1: wb_valid_o=1, wb_tag_o=5, wb_dst_o=7, disp_eu_valid_o=1, disp_eu_tag_o=5.
- All-request round robin: EU0..3 valid continuously, tags 0..3 held, wb_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles. Release pulses show tags 0,1,2,3,0 one cycle later.
- Backpressure:
  - Held tag=3, wb_ready_i=0 for 4 cycles -> wb_* stable, eu_ready_o=0, disp_eu_valid_o=0 throughout.
  - On wb_ready_i=1 -> release tag 3 and grant the next requester in the same cycle.
- Wrap/skip: pointer=3, only EU1 valid -> EU1 granted; pointer becomes 2. Next, EU0 and EU2 valid -> EU2 granted first.
- Reset mid-operation: held tag=6, EU1 valid, assert rst_i asynchronously -> wb_valid_o=0 immediately, no release pulse for 6. After release, EU1 is granted first (pointer=0, EU0 idle).
- Idle: no eu_valid_i for 10 cycles after a drain -> wb_valid_o=0, disp_eu_valid_o=0, pointer unchanged.
